// File: rtl/ad_sj.sv
// ad_sj: periodic sampler for a parallel ADC with a wr/intr/rd handshake.
// Define AD_TIMEOUT_EN to abort a conversion (err pulse) when intr never arrives.
module ad_sj #(
    parameter int SAMPLE_CNT = 7313,
    parameter int WR_LOW     = 3,
    parameter int RD_LOW     = 4,
    parameter int TIMEOUT    = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       intr,
    input  logic [7:0] din,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       err
);

    localparam int TW     = $clog2(SAMPLE_CNT + 1);
    localparam int PH_MAX = (WR_LOW > RD_LOW) ? WR_LOW : RD_LOW;
    localparam int PW     = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, READ} state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tmr_reg;
    logic [PW-1:0]   ph_reg, ph_next;
    logic [1:0]      sync_reg;
    logic            intr_s;
    logic            trigger;
    logic            capture;
    logic            wait_hit;

    assign intr_s  = sync_reg[1];
    assign trigger = (tmr_reg == TW'(SAMPLE_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_reg  <= '0;
            sync_reg <= 2'b11;
        end else begin
            tmr_reg  <= trigger ? '0 : tmr_reg + 1'b1;
            sync_reg <= {sync_reg[0], intr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ph_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ph_reg    <= ph_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ph_next    = ph_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    state_next = START;
                    ph_next    = '0;
                end
            end
            START: begin
                if (ph_reg == PW'(WR_LOW - 1)) begin
                    state_next = WAIT;
                    ph_next    = '0;
                end else begin
                    ph_next = ph_reg + 1'b1;
                end
            end
            WAIT: begin
                if (!intr_s) begin
                    state_next = READ;
                    ph_next    = '0;
                end else if (wait_hit) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (ph_reg == PW'(RD_LOW - 1)) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end else begin
                    ph_next = ph_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so each is low exactly while its state is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs       <= 1'b1;
            wr       <= 1'b1;
            rd       <= 1'b1;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            cs       <= (state_next == IDLE);
            wr       <= (state_next != START);
            rd       <= (state_next != READ);
            dout_vld <= capture;
            if (capture) begin
                dout <= din;
            end
        end
    end

`ifdef AD_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);

    logic [WCW-1:0] wait_reg;
    logic           err_reg;

    assign wait_hit = (wait_reg == WCW'(TIMEOUT - 1));
    assign err      = err_reg;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            wait_reg <= (state_reg == WAIT) ? wait_reg + 1'b1 : '0;
            err_reg  <= (state_reg == WAIT) && intr_s && wait_hit;
        end
    end
`else
    assign wait_hit = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ad_sj.sv
// tb_ad_sj: randomized ADC handshake model and event-level scoreboard for ad_sj.
`timescale 1ns/1ps
module tb_ad_sj;

    localparam int N  = 100;
    localparam int WL = 3;
    localparam int RL = 4;
`ifdef AD_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 2500;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       intr  = 1'b1;
    logic [7:0] din   = 8'h00;
    logic       cs, wr, rd, dout_vld, err;
    logic [7:0] dout;

    ad_sj #(.SAMPLE_CNT(N), .WR_LOW(WL), .RD_LOW(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .intr(intr), .din(din),
        .cs(cs), .wr(wr), .rd(rd), .dout(dout), .dout_vld(dout_vld), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle index: edge k after reset release makes cyc == k.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ADC behaviour knobs
    int  adc_delay = 20;
    bit  adc_rand  = 0;
    bit  adc_glitch = 0;
    bit  adc_never = 0;
    int  din_mode  = 0;          // 0: 8'hA5, 1: ramp, 2: random
    logic [7:0] ramp_val = 8'h00;

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] last_dout = 8'h00;
    bit  prev_wr = 1, prev_rd = 1, armed = 0, glitch_on = 0;
    int  wr_len = 0, rd_len = 0, countdown = 0, outstanding = 0;
    int  next_wr_exp = N, wait_entry = 0, drop_cyc = 0;
    int  n_cap = 0, n_err = 0;
    int  excl_viol = 0, cs_viol = 0, hold_viol = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1; prev_rd = 1; wr_len = 0; rd_len = 0;
            outstanding = 0; next_wr_exp = N; exp_q.delete();
            last_dout = 8'h00; armed = 0; glitch_on = 0; intr = 1'b1;
        end else begin
            if (!wr && !rd) excl_viol++;
            if ((!wr || !rd) && cs) cs_viol++;
            if (!dout_vld && dout !== last_dout) hold_viol++;
            if (glitch_on) begin
                intr = 1'b1;
                glitch_on = 0;
            end
            // A conversion may only start on a period boundary with the previous one finished.
            if (!wr) begin
                if (prev_wr) begin
                    check("wr_start_cyc", cyc, next_wr_exp);
                    check("idle_at_trigger", outstanding, 0);
                    outstanding = 1;
                    wr_len = 0;
                    if (adc_glitch) begin
                        intr = 1'b0;
                        glitch_on = 1;
                    end
                end
                wr_len++;
            end else if (!prev_wr) begin
                check("wr_low_len", wr_len, WL);
                wait_entry = cyc;
                if (!adc_never) begin
                    armed = 1;
                    countdown = adc_rand ? $urandom_range(1, 40) : adc_delay;
                end
            end
            if (armed) begin
                if (countdown == 0) begin
                    case (din_mode)
                        0:       din = 8'hA5;
                        1: begin din = ramp_val; ramp_val = ramp_val + 8'd1; end
                        default: din = 8'($urandom);
                    endcase
                    exp_q.push_back(din);
                    intr = 1'b0;
                    drop_cyc = cyc;
                    armed = 0;
                end else begin
                    countdown--;
                end
            end
            if (!rd) begin
                if (prev_rd) begin
                    check("rd_latency", cyc - drop_cyc, 3);
                    rd_len = 0;
                end
                rd_len++;
                intr = 1'b1;
            end else if (!prev_rd) begin
                check("rd_low_len", rd_len, RL);
            end
            if (dout_vld) begin
                check("dout_q_size", exp_q.size(), 1);
                if (exp_q.size() > 0) exp_v = exp_q.pop_front();
                check("dout", dout, exp_v);
                check("busy_at_capture", outstanding, 1);
                outstanding = 0;
                last_dout = dout;
                next_wr_exp = (cyc / N + 1) * N;
                n_cap++;
                $display("capture %0d: cyc=%0d dout=%02h", n_cap, cyc, dout);
            end
            if (err) begin
                check("timeout_len", cyc - wait_entry, TO);
                check("timeout_cs", cs, 1);
                check("timeout_dout", dout, last_dout);
                check("timeout_busy", outstanding, 1);
                outstanding = 0;
                next_wr_exp = (cyc / N + 1) * N;
                n_err++;
                $display("timeout: cyc=%0d", cyc);
            end
            prev_wr = wr;
            prev_rd = rd;
        end
    end

    task automatic wait_caps(input int n, input int budget);
        int target;
        int i;
        target = n_cap + n;
        i = 0;
        while (n_cap < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("capture_count", n_cap, target);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("rst_strobes", {cs, wr, rd, dout_vld, err}, 5'b11100);
        check("rst_dout", dout, 8'h00);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // fixed data, fixed intr delay
        din_mode = 0; adc_delay = 20;
        wait_caps(3, 800);

        // ramp through the full code range and wrap, random intr delay
        din_mode = 1; adc_rand = 1;
        wait_caps(257, 257 * 200);

        // random data and delays
        din_mode = 2;
        wait_caps(20, 20 * 200);

        // intr glitch during START must be ignored
        adc_glitch = 1;
        wait_caps(3, 800);
        adc_glitch = 0;

`ifdef AD_TIMEOUT_EN
        begin
            int e0;
            int i;
            e0 = n_err;
            adc_never = 1;
            i = 0;
            while (n_err == e0 && i < 400) begin
                @(negedge clk);
                i++;
            end
            check("timeout_seen", n_err - e0, 1);
            adc_never = 0;
            wait_caps(2, 600);
        end
`else
        // intr held past the next trigger: that trigger is dropped
        adc_rand = 0; adc_delay = 150;
        wait_caps(2, 800);
        adc_rand = 1;
`endif

        // reset in the second rd-low cycle aborts the conversion
        begin
            int i;
            i = 0;
            while (rd !== 1'b0 && i < 400) begin
                @(negedge clk);
                i++;
            end
            check("rd_seen_before_rst", rd, 0);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("abort_strobes", {cs, wr, rd, dout_vld, err}, 5'b11100);
            check("abort_dout", dout, 8'h00);
            repeat (3) @(negedge clk);
            #1 rst_n = 1'b1;
        end
        wait_caps(2, 800);

        check("wr_rd_exclusive", excl_viol, 0);
        check("cs_low_with_strobe", cs_viol, 0);
        check("dout_hold", hold_viol, 0);
`ifndef AD_TIMEOUT_EN
        check("err_never", n_err, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ad_sj.md
AD_SJ -- requirements
Module: ad_sj

Interface
REQ-001 SHALL have parameter SAMPLE_CNT, default 7313; conversion-start period in clk cycles (period timer runs 0..SAMPLE_CNT-1).
REQ-002 SHALL have parameter WR_LOW, default 3; wr low-pulse width in cycles.
REQ-003 SHALL have parameter RD_LOW, default 4; rd low-pulse width in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 2500; max cycles waiting for intr (used only with AD_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port intr  input  1  ADC conversion-done, active-low, asynchronous to clk.
REQ-008 SHALL have port din  input  8  ADC parallel data bus.
REQ-009 SHALL have port cs  output  1  ADC chip select, active-low, registered.
REQ-010 SHALL have port wr  output  1  ADC start-conversion strobe, active-low, registered.
REQ-011 SHALL have port rd  output  1  ADC read strobe, active-low, registered.
REQ-012 SHALL have port dout  output  8  last captured sample, registered.
REQ-013 SHALL have port dout_vld  output  1  one-cycle pulse when dout updates.
REQ-014 SHALL have port err  output  1  one-cycle pulse on conversion timeout.

Function
REQ-015 Period timer SHALL count 0..SAMPLE_CNT-1 continuously after reset release and wrap to 0; terminal count = trigger.
REQ-016 intr SHALL pass through a 2-flop synchronizer (intr_s) before use; latency 2 cycles.
REQ-017 FSM states SHALL be IDLE, START, WAIT, READ; reset state IDLE.
REQ-018 IDLE->START on trigger; trigger arriving in any other state SHALL be ignored (no queueing).
REQ-019 START: wr=0 and cs=0 for exactly WR_LOW cycles, then ->WAIT with wr=1.
REQ-020 WAIT: cs=0, wr=1, rd=1; ->READ on first cycle intr_s==0.
REQ-021 READ: rd=0 and cs=0 for exactly RD_LOW cycles; on the edge ending the last rd-low cycle, dout<=din, dout_vld=1 for one cycle, rd->1, state->IDLE.
REQ-022 IDLE: cs=1, wr=1, rd=1.
REQ-023 wr and rd SHALL never be low in the same cycle.
REQ-024 dout SHALL hold its value between captures; dout_vld SHALL be 0 except the capture cycle.
REQ-025 intr low while in IDLE or START SHALL be ignored.

Reset
REQ-026 On rst_n=0, asynchronously: cs=1, wr=1, rd=1, dout=0, dout_vld=0, err=0, period timer=0, synchronizer flops=1, state=IDLE.
REQ-027 Reset asserted mid-conversion SHALL abort immediately; no dout update, no dout_vld pulse.
REQ-028 After rst_n release, first trigger SHALL occur SAMPLE_CNT cycles later.

Configuration
REQ-029 Macro AD_TIMEOUT_EN defined: a wait counter SHALL clear on WAIT entry; if TIMEOUT cycles pass in WAIT without intr_s==0, FSM->IDLE, err=1 for one cycle, dout unchanged.
REQ-030 AD_TIMEOUT_EN undefined: WAIT SHALL persist until intr_s==0; err tied 0; no wait counter synthesized.

Verification
REQ-031 SAMPLE_CNT=100, ADC model drops intr 20 cycles after wr rises, din=8'hA5 -> wr low 3 cycles, rd low 4 cycles, dout=8'hA5 with one dout_vld pulse; repeats every 100 cycles.
REQ-032 din ramps 0..255 per conversion -> dout sequence 0,1,...,255,0 with one dout_vld per sample, never two per period.
REQ-033 ADC model holds intr high past next trigger (SAMPLE_CNT=100, intr at 150 cycles) -> second trigger ignored, exactly one capture, wr not re-pulsed during WAIT.
REQ-034 AD_TIMEOUT_EN, TIMEOUT=50, intr never asserted -> err pulse 50 cycles after WAIT entry, cs=1 next cycle, dout unchanged, next trigger restarts normally.
REQ-035 rst_n pulsed low during READ (cycle 2 of 4) -> outputs at reset values immediately, no dout_vld, first new wr low 100 cycles after release.
REQ-036 intr glitch low during START -> ignored; capture only after intr asserted in WAIT; wr/rd never simultaneously low (assertion throughout).
